// File: rtl/exp_sweep_ctrl.sv
// Exhaustive 3-input sweep controller: drives all eight vectors into an external
// datapath, checks each response against majority and reports the result.
module exp_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [7:0] FAIL_VEC
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_r, state_s;
  logic [2:0] idx_r, idx_s;
  logic [3:0] cnt_r, cnt_s;
  logic [3:0] err_cnt_r, err_cnt_s;
  logic [7:0] fail_vec_r, fail_vec_s;
  logic       pass_r, pass_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic [2:0] abc_r, abc_s;

  function automatic logic maj3(input logic [2:0] v);
    return (v[2] & v[1]) | (v[1] & v[0]) | (v[0] & v[2]);
  endfunction

  // Next-state, result-update and next-output logic.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    err_cnt_s  = err_cnt_r;
    fail_vec_s = fail_vec_r;
    pass_s     = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s    = ST_WAIT;
          idx_s      = 3'd0;
          cnt_s      = 4'd0;
          err_cnt_s  = 4'd0;
          fail_vec_s = 8'd0;
          pass_s     = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (Y != maj3(idx_r)) begin
          err_cnt_s  = err_cnt_r + 4'd1;
          fail_vec_s = fail_vec_r | (8'd1 << idx_r);
        end else begin
          err_cnt_s  = err_cnt_r;
        end
        // PASS is decided from the count that includes this last sample.
        if (idx_r == 3'd7) begin
          state_s = ST_FIN;
          pass_s  = (err_cnt_s == 4'd0);
        end else begin
          state_s = ST_WAIT;
          idx_s   = idx_r + 3'd1;
          cnt_s   = 4'd0;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_WAIT) || (state_s == ST_SAMPLE);
    done_s = (state_s == ST_FIN);
    if (busy_s) begin
      abc_s = idx_s;
    end else begin
      abc_s = 3'd0;
    end
  end

  // State, results and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      cnt_r      <= 4'd0;
      err_cnt_r  <= 4'd0;
      fail_vec_r <= 8'd0;
      pass_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      abc_r      <= 3'd0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      err_cnt_r  <= err_cnt_s;
      fail_vec_r <= fail_vec_s;
      pass_r     <= pass_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      abc_r      <= abc_s;
    end
  end

  assign A        = abc_r[2];
  assign B        = abc_r[1];
  assign C        = abc_r[0];
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign PASS     = pass_r;
  assign ERR_CNT  = err_cnt_r;
  assign FAIL_VEC = fail_vec_r;

endmodule

// File: tb/tb_exp_sweep_ctrl.sv
// Bench for exp_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1) driven by
// configurable datapath models, checked cycle by cycle against a timing/result model.
module tb_exp_sweep_ctrl;

  logic       clk = 1'b0;
  logic [1:0] rst_v, start_v, y_v;
  logic [1:0] a_v, b_v, c_v, busy_v, done_v, pass_v;
  logic [3:0] err_v [2];
  logic [7:0] fv_v [2];
  int         mode_v [2];
  logic [7:0] mask_v [2];
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  // Datapath model: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted, 4 per-vector fault mask.
  function automatic logic yfn(input int mode, input logic [7:0] mask, input logic [2:0] v);
    logic m;
    m = ($countones(v) >= 2);
    case (mode)
      0:       return m;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~m;
      default: return m ^ mask[v];
    endcase
  endfunction

  assign y_v[0] = yfn(mode_v[0], mask_v[0], {a_v[0], b_v[0], c_v[0]});
  assign y_v[1] = yfn(mode_v[1], mask_v[1], {a_v[1], b_v[1], c_v[1]});

  exp_sweep_ctrl #(.SETTLE(2)) dut0 (
    .CLK(clk), .RST(rst_v[0]), .START(start_v[0]), .Y(y_v[0]),
    .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]),
    .PASS(pass_v[0]), .ERR_CNT(err_v[0]), .FAIL_VEC(fv_v[0])
  );

  exp_sweep_ctrl #(.SETTLE(1)) dut1 (
    .CLK(clk), .RST(rst_v[1]), .START(start_v[1]), .Y(y_v[1]),
    .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]),
    .PASS(pass_v[1]), .ERR_CNT(err_v[1]), .FAIL_VEC(fv_v[1])
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expd, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] abc_of(input int d);
    return {a_v[d], b_v[d], c_v[d]};
  endfunction

  // One sweep on instance d; optional extra START pulse and mid-sweep reset at given edges.
  task automatic sweep(input int d, input int s, input int mode, input logic [7:0] mask,
                       input int pulse_k, input int rst_k);
    int         t;
    int         nsamp;
    logic [7:0] exp_fv;
    logic [7:0] part;
    t = 8 * (s + 1);
    exp_fv = 8'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = 3'(i);
      exp_fv[i] = (yfn(mode, mask, v3) != ($countones(v3) >= 2));
    end
    mode_v[d] = mode;
    mask_v[d] = mask;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    chk_val("accept_busy", 32'(busy_v[d]), 32'd1);
    chk_val("accept_pass_clr", 32'(pass_v[d]), 32'd0);
    chk_val("accept_err_clr", 32'(err_v[d]), 32'd0);
    chk_val("accept_fv_clr", 32'(fv_v[d]), 32'd0);
    chk_val("accept_abc", 32'(abc_of(d)), 32'd0);
    for (int k = 1; k <= t; k++) begin
      start_v[d] = (k == pulse_k) ? 1'b1 : 1'b0;
      if (k == rst_k) begin
        rst_v[d] = 1'b1;
        tick();
        rst_v[d] = 1'b0;
        start_v[d] = 1'b0;
        chk_val("rst_busy", 32'(busy_v[d]), 32'd0);
        chk_val("rst_err", 32'(err_v[d]), 32'd0);
        chk_val("rst_abc", 32'(abc_of(d)), 32'd0);
        chk_val("rst_done", 32'(done_v[d]), 32'd0);
        chk_val("rst_fv", 32'(fv_v[d]), 32'd0);
        for (int j = 0; j < t; j++) begin
          tick();
          chk_val("abort_nodone", 32'(done_v[d]), 32'd0);
          chk_val("abort_idle", 32'(busy_v[d]), 32'd0);
        end
        return;
      end
      tick();
      start_v[d] = 1'b0;
      nsamp = k / (s + 1);
      part = 8'd0;
      for (int i = 0; i < nsamp; i++) part[i] = exp_fv[i];
      chk_val("run_err", 32'(err_v[d]), 32'($countones(part)));
      chk_val("run_fv", 32'(fv_v[d]), 32'(part));
      if (k < t) begin
        chk_val("run_abc", 32'(abc_of(d)), 32'(k / (s + 1)));
        chk_val("run_busy", 32'(busy_v[d]), 32'd1);
        chk_val("run_done", 32'(done_v[d]), 32'd0);
      end else begin
        chk_val("fin_abc", 32'(abc_of(d)), 32'd0);
        chk_val("fin_busy", 32'(busy_v[d]), 32'd0);
        chk_val("fin_done", 32'(done_v[d]), 32'd1);
        chk_val("fin_pass", 32'(pass_v[d]), 32'(exp_fv == 8'd0));
      end
    end
    tick();
    chk_val("idle_done", 32'(done_v[d]), 32'd0);
    chk_val("idle_busy", 32'(busy_v[d]), 32'd0);
    chk_val("idle_pass_hold", 32'(pass_v[d]), 32'(exp_fv == 8'd0));
    chk_val("idle_err_hold", 32'(err_v[d]), 32'($countones(exp_fv)));
    chk_val("idle_fv_hold", 32'(fv_v[d]), 32'(exp_fv));
  endtask

  initial begin
    int t;
    rst_v = 2'b11;
    start_v = 2'b00;
    mode_v[0] = 0; mode_v[1] = 0;
    mask_v[0] = 8'd0; mask_v[1] = 8'd0;
    tick();
    tick();
    rst_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk_val("reset_busy", 32'(busy_v[d]), 32'd0);
      chk_val("reset_done", 32'(done_v[d]), 32'd0);
      chk_val("reset_pass", 32'(pass_v[d]), 32'd0);
      chk_val("reset_err", 32'(err_v[d]), 32'd0);
      chk_val("reset_fv", 32'(fv_v[d]), 32'd0);
      chk_val("reset_abc", 32'(abc_of(d)), 32'd0);
    end
    tick();

    // Directed sweeps on SETTLE=2: correct, stuck-0, stuck-1, inverted.
    sweep(0, 2, 0, 8'd0, -1, -1);
    sweep(0, 2, 1, 8'd0, -1, -1);
    chk_val("stuck0_fv", 32'(fv_v[0]), 32'h0000_00E8);
    sweep(0, 2, 2, 8'd0, -1, -1);
    chk_val("stuck1_fv", 32'(fv_v[0]), 32'h0000_0017);
    sweep(0, 2, 3, 8'd0, -1, -1);
    chk_val("inv_err", 32'(err_v[0]), 32'd8);

    // Extra START during index 3 is ignored; then reset during index 5 aborts.
    sweep(0, 2, 1, 8'd0, 9, -1);
    sweep(0, 2, 1, 8'd0, 9, 16);
    sweep(0, 2, 0, 8'd0, -1, -1);

    // SETTLE=1: failing sweep, then a correct one clears the results.
    sweep(1, 1, 3, 8'd0, -1, -1);
    sweep(1, 1, 0, 8'd0, -1, -1);

    // START held high: back-to-back sweeps separated by one IDLE cycle.
    t = 24;
    mode_v[0] = 2;
    start_v[0] = 1'b1;
    tick();
    for (int e = 1; e <= 2 * t + 2; e++) begin
      tick();
      chk_val("held_done", 32'(done_v[0]), 32'((e == t) || (e == 2 * t + 2)));
      if (e == t) begin
        chk_val("held_first_err", 32'(err_v[0]), 32'd4);
        chk_val("held_first_pass", 32'(pass_v[0]), 32'd0);
        mode_v[0] = 0;
      end
      if (e == t + 1) chk_val("held_gap_busy", 32'(busy_v[0]), 32'd0);
      if (e == t + 2) begin
        chk_val("held_restart_busy", 32'(busy_v[0]), 32'd1);
        chk_val("held_restart_err", 32'(err_v[0]), 32'd0);
        chk_val("held_restart_fv", 32'(fv_v[0]), 32'd0);
      end
      if (e == 2 * t + 2) begin
        chk_val("held_second_pass", 32'(pass_v[0]), 32'd1);
        chk_val("held_second_err", 32'(err_v[0]), 32'd0);
      end
    end
    start_v[0] = 1'b0;
    tick();
    tick();
    chk_val("held_stop_busy", 32'(busy_v[0]), 32'd0);

    // Random per-vector fault masks on both instances.
    for (int r = 0; r < 8; r++) begin
      int d;
      d = r % 2;
      sweep(d, (d == 1) ? 1 : 2, 4, 8'($urandom), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
